// File: rtl/game_pkg.sv
// Shared types and sizes for the memory game datapath.
package game_pkg;

   localparam int P_BTN       = 4;
   localparam int P_IDX       = 4;
   localparam int P_TMR       = 26;
   localparam int TIMEOUT_CYC = 50000000;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WAIT_PRESS   = 3'd1,
      WAIT_RELEASE = 3'd2,
      CHECK        = 3'd3,
      DONE         = 3'd4,
      FAIL         = 3'd5
   } state_t;

   function automatic logic is_onehot(input logic [P_BTN-1:0] v);
      return $onehot(v);
   endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Saturating timer that flags when the press window has run out.
module inactivity_timer #(
   parameter int P_TMR       = 26,
   parameter int TIMEOUT_CYC = 50000000
) (
   input  logic clk,
   input  logic R,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [P_TMR-1:0] LAST = P_TMR'(TIMEOUT_CYC - 1);

   logic [P_TMR-1:0] count;

   // Holds at LAST so a long idle never wraps into a false window.
   always_ff @(posedge clk) begin
      if (R || clear)
         count <= '0;
      else if (enable && count != LAST)
         count <= count + 1'b1;
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/seq_checker.sv
// Compares player presses against the ROM sequence for one round.
module seq_checker #(
   parameter int P_TMR       = game_pkg::P_TMR,
   parameter int TIMEOUT_CYC = game_pkg::TIMEOUT_CYC
) (
   input  logic                       clk,
   input  logic                       R,
   input  logic                       start,
   input  logic [game_pkg::P_IDX-1:0] round,
   input  logic [game_pkg::P_BTN-1:0] seq_word,
   input  logic [game_pkg::P_BTN-1:0] btn,
   output logic [game_pkg::P_IDX-1:0] seq_addr,
   output logic                       round_done,
   output logic                       fail,
   output logic                       busy
);

   import game_pkg::*;

   state_t           state, nxt;
   logic [P_IDX-1:0] idx, idx_nxt;
   logic [P_BTN-1:0] latched, latched_nxt;
   logic             tmr_en, tmr_clr, expired;

   always_ff @(posedge clk) begin
      if (R) begin
         state   <= IDLE;
         idx     <= '0;
         latched <= '0;
      end else begin
         state   <= nxt;
         idx     <= idx_nxt;
         latched <= latched_nxt;
      end
   end

   always_comb begin
      nxt         = state;
      idx_nxt     = idx;
      latched_nxt = latched;
      unique case (state)
         IDLE, FAIL: begin
            if (start) begin
               nxt     = WAIT_PRESS;
               idx_nxt = '0;
            end
         end
         // A press beats a timeout landing in the same cycle.
         WAIT_PRESS: begin
            if (btn != '0) begin
               if (is_onehot(btn)) begin
                  latched_nxt = btn;
                  nxt         = WAIT_RELEASE;
               end else begin
                  nxt = FAIL;
               end
            end else if (expired) begin
               nxt = FAIL;
            end
         end
         WAIT_RELEASE: begin
            if ((btn & ~latched) != '0)
               nxt = FAIL;
            else if (btn == '0)
               nxt = CHECK;
         end
         CHECK: begin
            if (latched != seq_word) begin
               nxt = FAIL;
            end else if (idx == round) begin
               nxt = DONE;
            end else begin
               idx_nxt = idx + 1'b1;
               nxt     = WAIT_PRESS;
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Timer runs only while waiting, so every entry starts from zero.
   assign tmr_en  = (state == WAIT_PRESS);
   assign tmr_clr = ~tmr_en;

   inactivity_timer #(
      .P_TMR       (P_TMR),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_tmr (
      .clk     (clk),
      .R       (R),
      .clear   (tmr_clr),
      .enable  (tmr_en),
      .expired (expired)
   );

   assign seq_addr   = idx;
   assign round_done = (state == DONE);
   assign fail       = (state == FAIL);
   assign busy       = (state != IDLE) && (state != FAIL);

endmodule
